data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder end of the pipeline's data-memory access. Accepts one word read or
//   write request over a valid/ready channel, holds it for a fixed access latency,
//   then returns a response (read data or write ack, plus error flag) over a
//   second valid/ready channel. Replaces the zero-wait data memory at the MEM stage
//   for stall/wait-state testing. One transaction outstanding at a time.
// PARAMETERS
//   DEPTH_WORDS  256  number of 32-bit words stored
//   LATENCY      2    wait cycles between acceptance and response (0..15)
//   ADDR_W       32   request byte-address width
// PORTS
//   CLK        in   1       clock, all state updates on rising edge
//   RST        in   1       reset, synchronous, active-high
//   req_valid  in   1       request present
//   req_ready  out  1       responder can accept a request
//   req_we     in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   32      write data
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       initiator takes response
//   rsp_rdata  out  32      read data; 0 for writes and errors
//   rsp_err    out  1       misaligned or out-of-range access
// BEHAVIOUR
//   Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//     Memory contents are NOT reset.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata;
//     go WAIT with counter=LATENCY-1, or straight to RESP if LATENCY==0.
//   - WAIT: req_ready=0. Decrement counter; at 0 go RESP.
//   - On entering RESP (same edge): decode access; err = (addr[1:0]!=0) ||
//     (addr[ADDR_W-1:2] >= DEPTH_WORDS). Read ok: rsp_rdata=mem[addr>>2].
//     Write ok: mem[addr>>2]=wdata committed on that edge, rsp_rdata=0.
//     Error: no memory change, rsp_rdata=0, rsp_err=1.
//   - RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready. On
//     rsp_valid&&rsp_ready go IDLE; rsp_valid, rsp_rdata, rsp_err clear to 0.
//   Latency: rsp_valid first high LATENCY+1 cycles after the acceptance cycle.
//   Throughput: no overlap; req_ready returns the cycle after response handshake,
//     so at most one transaction per LATENCY+2 cycles.
//   req_* inputs ignored outside the IDLE acceptance cycle (captured values used).
//   rsp_ready held low: response held indefinitely, no new request accepted.
//   Reset mid-operation: transaction dropped; a write still in WAIT is never
//     committed; a write already in RESP stays committed.
//   Read-after-write to same word returns newly written data.
// TESTING
//   1. Reset, LATENCY=2: write 0xDEADBEEF @0x10 -> rsp_valid 3 cycles after
//      accept, err=0, rdata=0; then read @0x10 -> rdata=0xDEADBEEF.
//   2. Read @0x13 -> err=1, rdata=0; read @0x400 (DEPTH 256) -> err=1; write
//      @0x402 -> err=1 and word 0x400>>2 region unchanged.
//   3. Hold rsp_ready=0 for 10 cycles -> rsp_valid, rdata stable, req_ready=0
//      throughout; release -> IDLE, req_ready=1 next cycle.
//   4. Assert RST during WAIT of write 0x12345678 @0x20 -> outputs reset;
//      subsequent read @0x20 returns prior contents, not 0x12345678.
//   5. LATENCY=0 build: back-to-back requests with rsp_ready=1 -> one response
//      every 2 cycles, rsp_valid 1 cycle after each acceptance.
//   6. Random read/write sequence vs. scoreboard model -> all rdata/err match.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word read/write, waits LATENCY cycles,
// then presents a response (read data or write ack with error flag).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]        CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [ADDR_W-3:0] DEPTH_L  = (ADDR_W-2)'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              go_resp;
  logic              dec_we;
  logic [ADDR_W-1:0] dec_addr;
  logic [31:0]       dec_wdata;
  logic              dec_err;
  logic [IDX_W-1:0]  dec_idx;
  logic              mem_we;

  // With LATENCY==0 the access is decoded on the acceptance edge itself, so
  // the live request fields are used instead of the captured copies.
  always_comb begin
    accept    = (state_q == IDLE) && req_valid && req_ready_q;
    go_resp   = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));
    dec_we    = (state_q == IDLE) ? req_we    : we_q;
    dec_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    dec_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    dec_err   = (dec_addr[1:0] != 2'b00) || (dec_addr[ADDR_W-1:2] >= DEPTH_L);
    dec_idx   = dec_addr[IDX_W+1:2];
    mem_we    = go_resp && dec_we && !dec_err && !RST;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[dec_idx] <= dec_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            cnt_q       <= CNT_INIT;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (go_resp) begin
        state_q     <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= dec_err;
        rsp_rdata_q <= (dec_we || dec_err) ? '0 : mem_q[dec_idx];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: transaction-level model checked every cycle,
// plus directed literal checks, including a zero-latency instance.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT), .ADDR_W(32)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .ADDR_W(32)) dut0 (
    .CLK(clk), .RST(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mmem [256];
  int          cyc = 0;
  bit          chk_en = 1'b0;

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: a response is owed from its due cycle until the handshake;
  // a write lands once its response is due, and a reset before that drops it.
  always @(posedge clk) begin
    if (q.size() > 0 && (rst || (cyc >= q[0].due && rsp_ready))) begin
      if (cyc >= q[0].due && q[0].we && !q[0].err) mmem[q[0].addr[9:2]] = q[0].wdata;
      void'(q.pop_front());
    end
    if (rst) q.delete();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic        pend, vld;
      logic [31:0] erd;
      logic        eer;
      pend = (q.size() > 0);
      vld  = pend && (cyc >= q[0].due);
      erd  = vld ? q[0].rdata : 32'd0;
      eer  = vld ? q[0].err : 1'b0;
      chk("req_ready", 32'(req_ready), 32'(!pend));
      chk("rsp_valid", 32'(rsp_valid), 32'(vld));
      chk("rsp_rdata", rsp_rdata, erd);
      chk("rsp_err",   32'(rsp_err), 32'(eer));
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    ent_t e;
    int   n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    e.we = we; e.addr = addr; e.wdata = wd; e.err = model_err(addr);
    e.rdata = (!e.err && !we) ? mmem[addr[9:2]] : 32'd0;
    e.due = cyc + LAT;
    q.push_back(e);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic finish_rsp(input int hold, output logic [31:0] rd, output logic er, output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata; er = rsp_err;
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input int hold, output logic [31:0] rd, output logic er);
    int n;
    issue(we, addr, wd);
    finish_rsp(hold, rd, er, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    logic [31:0] z_addr [4];
    logic        z_we   [4];
    logic [31:0] z_wd   [4];
    logic [31:0] z_exp  [4];

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Write then read back, with first-response latency
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    finish_rsp(0, rd, er, n);
    chk("t1_wr_rdata", rd, 32'd0);
    chk("t1_wr_err", 32'(er), 32'd0);
    chk("t1_latency", 32'(n + 1), 32'd3);
    xact(1'b0, 32'h10, 32'h0, 0, rd, er);
    chk("t1_rd_rdata", rd, 32'hDEADBEEF);
    chk("t1_rd_err", 32'(er), 32'd0);

    // Error decoding and boundary words
    xact(1'b1, 32'h3FC, 32'hCAFEF00D, 0, rd, er);
    xact(1'b1, 32'h0,   32'h11111111, 1, rd, er);
    xact(1'b0, 32'h13,  32'h0, 0, rd, er);
    chk("t2_mis_err", 32'(er), 32'd1);
    chk("t2_mis_rdata", rd, 32'd0);
    xact(1'b0, 32'h400, 32'h0, 0, rd, er);
    chk("t2_oor_err", 32'(er), 32'd1);
    xact(1'b1, 32'h402, 32'hBAD0BAD0, 0, rd, er);
    chk("t2_wr402_err", 32'(er), 32'd1);
    chk("t2_wr402_rdata", rd, 32'd0);
    xact(1'b1, 32'h400, 32'hBAD1BAD1, 0, rd, er);
    chk("t2_wr400_err", 32'(er), 32'd1);
    xact(1'b0, 32'h3FC, 32'h0, 0, rd, er);
    chk("t2_last_word", rd, 32'hCAFEF00D);
    xact(1'b0, 32'h0, 32'h0, 0, rd, er);
    chk("t2_word0", rd, 32'h11111111);

    // Backpressure on the response channel
    xact(1'b1, 32'h20, 32'hAAAA5555, 0, rd, er);
    xact(1'b0, 32'h10, 32'h0, 10, rd, er);
    chk("t3_rdata", rd, 32'hDEADBEEF);
    chk("t3_ready_after", 32'(req_ready), 32'd1);

    // Reset during WAIT drops the write
    issue(1'b1, 32'h20, 32'h12345678);
    rst = 1'b1; chk_en = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("t4_wait_reset");
    rst = 1'b0; chk_en = 1'b1;
    xact(1'b0, 32'h20, 32'h0, 0, rd, er);
    chk("t4_prior", rd, 32'hAAAA5555);

    // Reset during RESP keeps the write
    issue(1'b1, 32'h24, 32'h77777777);
    finish_rsp_wait: begin
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    end
    rst = 1'b1; chk_en = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("t4_resp_reset");
    rst = 1'b0; chk_en = 1'b1;
    xact(1'b0, 32'h24, 32'h0, 0, rd, er);
    chk("t4_kept", rd, 32'h77777777);

    // Zero-latency instance: back-to-back traffic, response every 2 cycles
    z_addr[0] = 32'h0; z_we[0] = 1'b1; z_wd[0] = 32'hA5A5A5A5; z_exp[0] = 32'h0;
    z_addr[1] = 32'h4; z_we[1] = 1'b1; z_wd[1] = 32'h5A5A5A5A; z_exp[1] = 32'h0;
    z_addr[2] = 32'h0; z_we[2] = 1'b0; z_wd[2] = 32'h0;        z_exp[2] = 32'hA5A5A5A5;
    z_addr[3] = 32'h4; z_we[3] = 1'b0; z_wd[3] = 32'h0;        z_exp[3] = 32'h5A5A5A5A;
    z_rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      z_req_valid = 1'b1;
      z_req_we    = z_we[c / 2];
      z_req_addr  = z_addr[c / 2];
      z_req_wdata = z_wd[c / 2];
      @(negedge clk);
      chk("t5_req_ready", 32'(z_req_ready), 32'((c % 2) == 0));
      chk("t5_rsp_valid", 32'(z_rsp_valid), 32'((c % 2) == 1));
      chk("t5_rsp_rdata", z_rsp_rdata, ((c % 2) == 1) ? z_exp[c / 2] : 32'd0);
      chk("t5_rsp_err", 32'(z_rsp_err), 32'd0);
      @(posedge clk); #1;
    end
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;

    // Random traffic over a small window including misaligned and out-of-range
    for (int w = 0; w < 8; w++) xact(1'b1, 32'h80 + 32'(w * 4), $urandom, 0, rd, er);
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int          kind;
      kind = $urandom_range(0, 9);
      a = 32'h80 + 32'($urandom_range(0, 7) * 4);
      if (kind == 8) a = a + 32'($urandom_range(1, 3));
      if (kind == 9) a = 32'h400 + 32'($urandom_range(0, 63) * 4);
      xact(1'($urandom), a, $urandom, $urandom_range(0, 3), rd, er);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
